// File: rtl/addr_stack.sv
// Program counter plus DEPTH-entry circular return stack, updated once per instruction at cycle 7.
// Define ADDR_STACK_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module addr_stack #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            cycle,
    input  logic [1:0]            control,
    input  logic [ADDR_WIDTH-1:0] target,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_enable,
    output logic [3:0]            pc_word,
    output logic [4:0]            stack_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int NIBBLES = ADDR_WIDTH / 4;
    localparam int SP_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_LAST   = SP_W'(DEPTH - 1);
    localparam logic [4:0]      DEPTH_CNT = 5'(DEPTH);

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_JUMP = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    if ((ADDR_WIDTH % 4) != 0 || ADDR_WIDTH < 4 || NIBBLES > 8) begin : g_bad_width
        $error("addr_stack: ADDR_WIDTH must be a multiple of 4 in 4..32");
    end
    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("addr_stack: DEPTH must be in 1..16");
    end

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [SP_W-1:0]       sp_q, sp_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] stack_q [DEPTH];
    logic [ADDR_WIDTH-1:0] stack_d [DEPTH];

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [SP_W-1:0]       sp_inc, sp_dec;
    logic                  update;

    assign update = (cycle == 3'd7);
    assign pc_inc = pc_q + 1'b1;
    // DEPTH need not be a power of two, so the pointer wraps explicitly.
    assign sp_inc = (sp_q == SP_LAST) ? '0 : sp_q + 1'b1;
    assign sp_dec = (sp_q == '0) ? SP_LAST : sp_q - 1'b1;

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        stack_d = stack_q;
        if (update) begin
            case (control)
                OP_INC:  pc_d = pc_inc;
                OP_JUMP: pc_d = target;
                OP_CALL: begin
                    stack_d[sp_q] = pc_inc;
                    sp_d          = sp_inc;
                    pc_d          = target;
                    cnt_d         = (cnt_q == DEPTH_CNT) ? cnt_q : cnt_q + 5'd1;
                end
                OP_RET: begin
                    sp_d  = sp_dec;
                    pc_d  = stack_q[sp_dec];
                    cnt_d = (cnt_q == 5'd0) ? cnt_q : cnt_q - 5'd1;
                end
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            sp_q    <= '0;
            cnt_q   <= '0;
            stack_q <= '{default: '0};
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            stack_q <= stack_d;
        end
    end

`ifdef ADDR_STACK_FLAGS_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (update && control == OP_CALL && cnt_q == DEPTH_CNT) ovf_d = 1'b1;
        if (update && control == OP_RET && cnt_q == 5'd0)       unf_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    // Zero-extend so every 3-bit cycle value selects an in-range nibble.
    logic [31:0] pc_ext;
    assign pc_ext      = 32'(pc_q);
    assign pc_enable   = ({1'b0, cycle} < 4'(NIBBLES));
    assign pc_word     = pc_enable ? pc_ext[{cycle, 2'b00} +: 4] : 4'h0;
    assign pc          = pc_q;
    assign stack_count = cnt_q;

endmodule

// File: tb/tb_addr_stack.sv
// Bench for addr_stack: vector table with a scoreboard queue, plus reset and 16-bit address sequences.
module tb_addr_stack;

`ifdef ADDR_STACK_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    localparam logic [1:0] INC = 2'b00, JMP = 2'b01, CALL = 2'b10, RET = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  cycle = 3'd0;
    logic [1:0]  control = 2'b00;
    logic [11:0] target = 12'h000;
    logic [15:0] target16 = 16'hBEEF;

    logic [11:0] pc;
    logic        pc_enable;
    logic [3:0]  pc_word;
    logic [4:0]  stack_count;
    logic        overflow, underflow;

    logic [15:0] pc16;
    logic        pc_enable16;
    logic [3:0]  pc_word16;
    logic [4:0]  stack_count16;
    logic        overflow16, underflow16;

    addr_stack #(.ADDR_WIDTH(12), .DEPTH(3)) u_dut (
        .clock(clock), .reset(reset), .cycle(cycle), .control(control), .target(target),
        .pc(pc), .pc_enable(pc_enable), .pc_word(pc_word), .stack_count(stack_count),
        .overflow(overflow), .underflow(underflow)
    );

    addr_stack #(.ADDR_WIDTH(16), .DEPTH(3)) u_dut16 (
        .clock(clock), .reset(reset), .cycle(cycle), .control(control), .target(target16),
        .pc(pc16), .pc_enable(pc_enable16), .pc_word(pc_word16), .stack_count(stack_count16),
        .overflow(overflow16), .underflow(underflow16)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [11:0] tgt;
        logic [11:0] pc;
        logic [4:0]  cnt;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t        tbl [21];
    vec_t        sb [$];
    logic [11:0] cur_pc = 12'h000;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_check();
        vec_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("pc", 32'(pc), 32'(e.pc));
        check("stack_count", 32'(stack_count), 32'(e.cnt));
        check("overflow", 32'(overflow), 32'(e.ovf & FLAGS));
        check("underflow", 32'(underflow), 32'(e.unf & FLAGS));
        cur_pc = e.pc;
    endtask

    // Garbage on control/target in cycles 0..6 must never move the PC.
    task automatic run_instr(input vec_t v);
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            pop_check();
            cycle = 3'(c);
            if (c == 7) begin
                control = v.ctrl;
                target  = v.tgt;
                sb.push_back(v);
            end else begin
                control = 2'($urandom_range(0, 3));
                target  = 12'($urandom());
            end
            @(negedge clock);
            check("pc_hold", 32'(pc), 32'(cur_pc));
            check("pc_enable", 32'(pc_enable), (c < 3) ? 32'd1 : 32'd0);
            check("pc_word", 32'(pc_word), (c < 3) ? 32'((cur_pc >> (4 * c)) & 12'hF) : 32'd0);
        end
    endtask

    initial begin
        tbl[0]  = '{INC,  12'h000, 12'h001, 5'd0, 1'b0, 1'b0};
        tbl[1]  = '{INC,  12'h000, 12'h002, 5'd0, 1'b0, 1'b0};
        tbl[2]  = '{INC,  12'h000, 12'h003, 5'd0, 1'b0, 1'b0};
        tbl[3]  = '{JMP,  12'hFFE, 12'hFFE, 5'd0, 1'b0, 1'b0};
        tbl[4]  = '{INC,  12'h000, 12'hFFF, 5'd0, 1'b0, 1'b0};
        tbl[5]  = '{INC,  12'h000, 12'h000, 5'd0, 1'b0, 1'b0};
        tbl[6]  = '{JMP,  12'hABC, 12'hABC, 5'd0, 1'b0, 1'b0};
        tbl[7]  = '{JMP,  12'h100, 12'h100, 5'd0, 1'b0, 1'b0};
        tbl[8]  = '{CALL, 12'h200, 12'h200, 5'd1, 1'b0, 1'b0};
        tbl[9]  = '{CALL, 12'h300, 12'h300, 5'd2, 1'b0, 1'b0};
        tbl[10] = '{RET,  12'h000, 12'h201, 5'd1, 1'b0, 1'b0};
        tbl[11] = '{RET,  12'h000, 12'h101, 5'd0, 1'b0, 1'b0};
        tbl[12] = '{JMP,  12'h010, 12'h010, 5'd0, 1'b0, 1'b0};
        tbl[13] = '{CALL, 12'h020, 12'h020, 5'd1, 1'b0, 1'b0};
        tbl[14] = '{CALL, 12'h030, 12'h030, 5'd2, 1'b0, 1'b0};
        tbl[15] = '{CALL, 12'h040, 12'h040, 5'd3, 1'b0, 1'b0};
        tbl[16] = '{CALL, 12'h050, 12'h050, 5'd3, 1'b1, 1'b0};
        tbl[17] = '{RET,  12'h000, 12'h041, 5'd2, 1'b1, 1'b0};
        tbl[18] = '{RET,  12'h000, 12'h031, 5'd1, 1'b1, 1'b0};
        tbl[19] = '{RET,  12'h000, 12'h021, 5'd0, 1'b1, 1'b0};
        tbl[20] = '{RET,  12'h000, 12'h041, 5'd0, 1'b1, 1'b1};

        repeat (2) @(posedge clock);
        #1;
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_count", 32'(stack_count), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_underflow", 32'(underflow), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) run_instr(tbl[i]);

        // Call writes stack[0]; stack[2] still holds 0x031, so only a real reset makes the next return read 0.
        run_instr('{CALL, 12'h5A5, 12'h5A5, 5'd1, 1'b1, 1'b1});
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            pop_check();
            cycle   = 3'(c);
            control = CALL;
            target  = 12'($urandom());
        end
        #2 reset = 1'b1;
        #1;
        check("async_reset_pc", 32'(pc), 32'd0);
        check("async_reset_count", 32'(stack_count), 32'd0);
        check("async_reset_overflow", 32'(overflow), 32'd0);
        check("async_reset_underflow", 32'(underflow), 32'd0);
        check("async_reset_pc_word", 32'(pc_word), 32'd0);
        cur_pc = 12'h000;
        @(negedge clock);
        reset = 1'b0;

        run_instr('{RET, 12'h000, 12'h000, 5'd0, 1'b0, 1'b1});
        run_instr('{JMP, 12'h777, 12'h777, 5'd0, 1'b0, 1'b1});

        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            pop_check();
            cycle   = 3'(c);
            control = INC;
            @(negedge clock);
            check("pc16", 32'(pc16), 32'h0000BEEF);
            check("pc_enable16", 32'(pc_enable16), (c < 4) ? 32'd1 : 32'd0);
            check("pc_word16", 32'(pc_word16), (c < 4) ? 32'((16'hBEEF >> (4 * c)) & 16'hF) : 32'd0);
        end

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/addr_stack.md
Name: addr_stack

Overview:
- Parametrised successor to the fixed 12-bit program-counter/return-stack block in the CPU top.
- Holds the active PC plus a DEPTH-entry circular return stack, and applies increment/jump/call/return once per instruction cycle.
- Drives the PC onto the nibble-wide bus during the address subcycles.
- Sits beside cpu_control; its cycle counter provides the timing and its decoded instructions provide control/target.

Parameters:
ADDR_WIDTH, 12, PC/target width in bits; must be a multiple of 4, range 4..32.
DEPTH, 3, number of return-stack entries (excluding the active PC); range 1..16, need not be a power of two.
NIBBLES, ADDR_WIDTH/4, derived (localparam): number of address subcycles.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
cycle  input  3  subcycle index 0..7 from cpu_control
control  input  2  00 increment, 01 jump, 10 call, 11 return
target  input  ADDR_WIDTH  jump/call destination
pc  output  ADDR_WIDTH  active program counter (registered)
pc_enable  output  1  high while pc_word must drive the data bus
pc_word  output  4  current PC nibble
stack_count  output  5  valid stack entries, 0..DEPTH
overflow  output  1  sticky call-overflow flag (see Optional Feature)
underflow  output  1  sticky return-underflow flag (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high. While asserted: pc=0, sp=0, stack_count=0, all stack entries=0, overflow=0, underflow=0. Reset mid-instruction abandons the operation; no partial update survives.
- Update point: state changes only on the rising clock edge where cycle==7. control and target are sampled at that edge only and ignored at all other edges.
- Increment (00): pc <= pc+1, wrapping modulo 2^ADDR_WIDTH (all-ones -> 0).
- Jump (01): pc <= target. Stack unchanged.
- Call (10):
  - stack[sp] <= pc+1 (wrapped); sp <= (sp+1) mod DEPTH; pc <= target.
  - stack_count <= min(stack_count+1, DEPTH).
  - When full, the write overwrites the oldest entry (circular, 4004-style).
- Return (11):
  - sp <= (sp-1) mod DEPTH; pc <= stack[(sp-1) mod DEPTH].
  - stack_count <= max(stack_count-1, 0).
  - On empty, the pointer still moves and pc loads whatever the slot holds (0 after reset).
- Address output:
  - pc_enable = (cycle < NIBBLES), combinational from cycle.
  - pc_word = pc[4*cycle+3 : 4*cycle] while pc_enable, least-significant nibble first (cycle 0 = bits 3:0); 4'h0 otherwise.
  - Because the PC updates at the cycle==7 edge, the next instruction's address nibbles reflect the new pc.
- NIBBLES > 8 is illegal: the address cannot fit in the 8 subcycles. An elaboration-time check rejects it.
- stack_count is zero-extended to 5 bits.

Optional Feature:
- Macro: ADDR_STACK_FLAGS_EN.
- Defined:
  - overflow sets (sticky) on a call when stack_count==DEPTH before the call.
  - underflow sets (sticky) on a return when stack_count==0 before the return.
  - Both clear only on reset.
- Undefined: overflow and underflow are tied to 0; no flag logic is built. All other behaviour is identical.

Test Plan (ADDR_WIDTH=12, DEPTH=3 unless noted):
- Reset, then run 3 instruction cycles with control=00 -> pc steps 0x000->0x001->0x002->0x003. In cycles 0/1/2 of the next instruction, pc_word=3,0,0 with pc_enable=1; in cycles 3..7, pc_enable=0.
- pc=0xFFE, two increments -> 0xFFF then 0x000. A jump with target=0xABC -> pc=0xABC, stack_count unchanged.
- From pc=0x100, call 0x200, then from 0x200 call 0x300 -> stack_count=2. Return -> pc=0x201; return -> pc=0x101; stack_count=0.
- Four nested calls from 0x010, 0x020, 0x030, 0x040 (targets 0x020, 0x030, 0x040, 0x050) -> stack_count=3, overflow=1 (flags build). Three returns yield 0x041, 0x031, 0x021; the 0x011 entry is lost.
- After reset, return with empty stack -> pc=0x000, stack_count=0, underflow=1 (flags build) or 0 (non-flags build). Change control/target at cycles 0..6 -> no pc change.
- Assert reset at cycle 4 after a call -> pc, stack_count, overflow and underflow are 0 immediately, before any clock edge. ADDR_WIDTH=16 build: pc_enable for cycles 0..3, nibbles emitted LSB first.
